// File: rtl/vga_game_pkg.sv
// Shared VGA game constants: colours, screen size, sprite plane mask and scheduler state encoding.
// Pure definitions only; no timing or flow-control behaviour of its own.
package vga_game_pkg;

  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  // Bit (py*5 + px); rows listed from py=4 (left) down to py=0 (right).
  localparam logic [24:0] PLANE_MASK = 25'b01110_00100_11111_00100_00000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNAP   = 3'd1,
    ST_ERASE  = 3'd2,
    ST_DRAW   = 3'd3,
    ST_FINISH = 3'd4
  } sched_state_e;

  function automatic logic mask_bit(input logic [2:0] px, input logic [2:0] py);
    logic [4:0] idx;
    idx = {2'b00, py} * 5'd5 + {2'b00, px};
    return PLANE_MASK[idx];
  endfunction

endpackage

// File: rtl/sprite_raster_counter.sv
// 5x5 raster walker, px fastest; clear wins over enable, last flags the (4,4) position.
// Zero-latency last flag from the registered position; no backpressure, advances only on enable.
module sprite_raster_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] px,
  output logic [2:0] py,
  output logic       last
);

  logic [2:0] px_q, px_d;
  logic [2:0] py_q, py_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clear) begin
      px_d = 3'd0;
      py_d = 3'd0;
    end else if (enable) begin
      if (px_q == 3'd4) begin
        px_d = 3'd0;
        py_d = (py_q == 3'd4) ? 3'd0 : py_q + 3'd1;
      end else begin
        px_d = px_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= 3'd0;
      py_q <= 3'd0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = (px_q == 3'd4) && (py_q == 3'd4);

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Time-shares the VGA write port: snapshot slots, erase all old sprites, draw all new ones; pixels 1 cycle after counter.
// Ticks arriving while busy are dropped; SPRITE_SCHED_OVERRUN_EN adds a sticky overrun flag for them.
module sprite_draw_scheduler
  import vga_game_pkg::*;
#(
  parameter int NUM_SLOTS = 10,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SCR_W     = SCR_W_DEF,
  parameter int SCR_H     = SCR_H_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_tick,
  input  logic [NUM_SLOTS*X_W-1:0] slot_x,
  input  logic [NUM_SLOTS*Y_W-1:0] slot_y,
  input  logic [NUM_SLOTS-1:0]     slot_vis,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     pass_done
`ifdef SPRITE_SCHED_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [X_W:0] SCR_W_LIM = (X_W + 1)'(SCR_W);
  localparam logic [Y_W:0] SCR_H_LIM = (Y_W + 1)'(SCR_H);

  sched_state_e state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic [X_W-1:0]       new_x_q [NUM_SLOTS];
  logic [Y_W-1:0]       new_y_q [NUM_SLOTS];
  logic [X_W-1:0]       old_x_q [NUM_SLOTS];
  logic [Y_W-1:0]       old_y_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] new_vis_q, old_vis_q;

  logic [X_W-1:0] pix_x_q;
  logic [Y_W-1:0] pix_y_q;
  logic [2:0]     pix_colour_q, colour_d;
  logic           pix_plot_q, plot_d;

  logic       cnt_clear, cnt_en, last;
  logic [2:0] px, py;

  logic           is_erase, cur_vis, in_bounds, advance;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  sprite_raster_counter u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .px     (px),
    .py     (py),
    .last   (last)
  );

  // Widened sums keep off-screen pixels from wrapping back onto the screen.
  always_comb begin
    is_erase  = (state_q == ST_ERASE);
    cur_vis   = is_erase ? old_vis_q[slot_q] : new_vis_q[slot_q];
    cur_x     = is_erase ? old_x_q[slot_q] : new_x_q[slot_q];
    cur_y     = is_erase ? old_y_q[slot_q] : new_y_q[slot_q];
    sum_x     = {1'b0, cur_x} + {{(X_W - 2){1'b0}}, px};
    sum_y     = {1'b0, cur_y} + {{(Y_W - 2){1'b0}}, py};
    in_bounds = (sum_x < SCR_W_LIM) && (sum_y < SCR_H_LIM);
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    plot_d    = 1'b0;
    colour_d  = COLOUR_BLACK;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        slot_d    = '0;
        cnt_clear = 1'b1;
        state_d   = ST_ERASE;
      end
      ST_ERASE, ST_DRAW: begin
        colour_d = is_erase ? COLOUR_BLACK : COLOUR_WHITE;
        if (!cur_vis) begin
          advance = 1'b1;
        end else begin
          plot_d = in_bounds && (is_erase || mask_bit(px, py));
          if (last) advance = 1'b1;
          else      cnt_en  = 1'b1;
        end
        if (advance) begin
          cnt_clear = 1'b1;
          if (slot_q == LAST_SLOT) begin
            slot_d  = '0;
            state_d = is_erase ? ST_DRAW : ST_FINISH;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= COLOUR_BLACK;
      pix_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pix_x_q      <= sum_x[X_W-1:0];
      pix_y_q      <= sum_y[Y_W-1:0];
      pix_colour_q <= colour_d;
      pix_plot_q   <= plot_d;
    end
  end

  // Old snapshot only takes the new one once the whole erase/draw pass is done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        new_x_q[k] <= '0;
        new_y_q[k] <= '0;
        old_x_q[k] <= '0;
        old_y_q[k] <= '0;
      end
      new_vis_q <= '0;
      old_vis_q <= '0;
    end else if (state_q == ST_SNAP) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        new_x_q[k] <= slot_x[k*X_W +: X_W];
        new_y_q[k] <= slot_y[k*Y_W +: Y_W];
      end
      new_vis_q <= slot_vis;
    end else if (state_q == ST_FINISH) begin
      old_x_q   <= new_x_q;
      old_y_q   <= new_y_q;
      old_vis_q <= new_vis_q;
    end
  end

  assign vga_x      = pix_x_q;
  assign vga_y      = pix_y_q;
  assign vga_colour = pix_colour_q;
  assign vga_plot   = pix_plot_q;
  assign busy       = (state_q != ST_IDLE);
  assign pass_done  = (state_q == ST_FINISH);

`ifdef SPRITE_SCHED_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overrun_q <= 1'b0;
    else if (frame_tick && busy) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed and randomized passes checked against a pixel-list model of the erase/draw scheduler.
module tb_sprite_draw_scheduler;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_tick;
  logic [N*8-1:0] slot_x;
  logic [N*7-1:0] slot_y;
  logic [N-1:0]   slot_vis;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           pass_done;
`ifdef SPRITE_SCHED_OVERRUN_EN
  logic           overrun;
`endif

  sprite_draw_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .slot_x    (slot_x),
    .slot_y    (slot_y),
    .slot_vis  (slot_vis),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy),
    .pass_done (pass_done)
`ifdef SPRITE_SCHED_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed    = 0;

  int       in_x [N];
  int       in_y [N];
  logic [N-1:0] in_vis;
  int       s_x [N];
  int       s_y [N];
  logic [N-1:0] s_vis;
  int       m_old_x [N];
  int       m_old_y [N];
  logic [N-1:0] m_old_vis;

  int exp_q[$];
  int obs_q[$];
  int exp_len, exp_erase_cyc;
  int last_len, last_black, last_white, last_offscreen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit mask_on(input int px, input int py);
    case (py)
      1:       return px == 2;
      2:       return 1'b1;
      3:       return px == 2;
      4:       return (px >= 1) && (px <= 3);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int pix_code(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      slot_x[k*8 +: 8] = 8'(in_x[k]);
      slot_y[k*7 +: 7] = 7'(in_y[k]);
    end
    slot_vis = in_vis;
  endtask

  task automatic build_expect();
    int x, y;
    s_x = in_x;
    s_y = in_y;
    s_vis = in_vis;
    exp_q.delete();
    exp_erase_cyc = 0;
    for (int k = 0; k < N; k++) begin
      if (m_old_vis[k]) begin
        exp_erase_cyc += 25;
        for (int py = 0; py < 5; py++)
          for (int px = 0; px < 5; px++) begin
            x = m_old_x[k] + px;
            y = m_old_y[k] + py;
            if (x < 160 && y < 120) exp_q.push_back(pix_code(x, y, 0));
          end
      end else begin
        exp_erase_cyc += 1;
      end
    end
    exp_len = 2 + exp_erase_cyc;
    for (int k = 0; k < N; k++) begin
      if (s_vis[k]) begin
        exp_len += 25;
        for (int py = 0; py < 5; py++)
          for (int px = 0; px < 5; px++) begin
            x = s_x[k] + px;
            y = s_y[k] + py;
            if (mask_on(px, py) && x < 160 && y < 120) exp_q.push_back(pix_code(x, y, 7));
          end
      end else begin
        exp_len += 1;
      end
    end
  endtask

  // tick_at: busy-cycle index for an extra tick (0 none, -1 the final cycle); abort_off: cycles into DRAW to reset.
  task automatic run_pass(input int tick_at, input int abort_off, input bit scramble);
    int busy_cnt, done_cnt, done_cyc, tick_cyc, abort_cyc, n;
    bit ended, aborted;
    build_expect();
    apply_inputs();
    tick_cyc  = (tick_at < 0) ? exp_len : tick_at;
    abort_cyc = (abort_off > 0) ? 2 + exp_erase_cyc + abort_off : 0;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; ended = 0; aborted = 0;
    obs_q.delete();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    for (int c = 0; c < 3000 && !ended; c++) begin
      if (!busy) begin
        ended = 1;
      end else begin
        busy_cnt++;
        if (vga_plot) obs_q.push_back(int'({vga_x, vga_y, vga_colour}));
        if (pass_done) begin
          done_cnt++;
          done_cyc = busy_cnt;
        end
        if (scramble && busy_cnt == 2) begin
          for (int k = 0; k < N; k++) begin
            in_x[k] = $urandom_range(0, 255);
            in_y[k] = $urandom_range(0, 127);
          end
          in_vis = N'($urandom);
          apply_inputs();
        end
        frame_tick = (busy_cnt == tick_cyc);
        if (abort_cyc != 0 && busy_cnt == abort_cyc) begin
          #2 reset_n = 1'b0;
          #1;
          check("abort_plot", vga_plot, 0);
          check("abort_busy", busy, 0);
          check("abort_pass_done", pass_done, 0);
          @(negedge clk) reset_n = 1'b1;
          aborted = 1;
          ended = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    frame_tick = 1'b0;
    check("pass_terminated", ended, 1);
    if (aborted) begin
      m_old_vis = '0;
    end else begin
      check("pass_len", busy_cnt, exp_len);
      check("pass_done_count", done_cnt, 1);
      check("pass_done_cycle", done_cyc, busy_cnt);
      check("plot_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("pixel_%0d", i), obs_q[i], exp_q[i]);
      last_len = busy_cnt;
      last_black = 0; last_white = 0; last_offscreen = 0;
      foreach (obs_q[i]) begin
        if ((obs_q[i] & 7) == 0) last_black++;
        if ((obs_q[i] & 7) == 7) last_white++;
        if ((obs_q[i] >> 10) >= 160 || ((obs_q[i] >> 3) & 127) >= 120) last_offscreen++;
      end
      m_old_x = s_x;
      m_old_y = s_y;
      m_old_vis = s_vis;
      if (tick_at != 0) begin
        repeat (3) @(negedge clk);
        check("no_second_pass", busy, 0);
`ifdef SPRITE_SCHED_OVERRUN_EN
        check("overrun_sticky", overrun, 1);
`endif
      end
    end
  endtask

  task automatic random_coords(input int xmax, input int ymax);
    for (int k = 0; k < N; k++) begin
      in_x[k] = $urandom_range(0, xmax);
      in_y[k] = $urandom_range(0, ymax);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    frame_tick = 1'b0;
    slot_x = '0;
    slot_y = '0;
    slot_vis = '0;
    m_old_vis = '0;
    for (int k = 0; k < N; k++) begin
      m_old_x[k] = 0;
      m_old_y[k] = 0;
    end
    #1;
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_busy", busy, 0);
    check("rst_pass_done", pass_done, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // First pass after reset: nothing to erase.
    random_coords(150, 110);
    in_vis = '0;
    in_vis[0] = 1'b1;
    in_x[0] = 10;
    in_y[0] = 20;
    run_pass(0, 0, 0);
    check("t1_first_white", (obs_q.size() > 0) ? obs_q[0] : -1, pix_code(12, 21, 7));
    check("t1_black", last_black, 0);
    check("t1_len", last_len, 46);

    in_y[0] = 21;
    run_pass(0, 0, 0);
    check("t2_black", last_black, 25);
    check("t2_white", last_white, 10);

    // Bottom-right corner: every mask pixel falls off-screen.
    in_x[0] = 158;
    in_y[0] = 118;
    run_pass(0, 0, 0);
    check("t3_offscreen", last_offscreen, 0);
    check("t3_len", last_len, 70);
    check("t3_white", last_white, 0);

    random_coords(150, 110);
    in_vis = '1;
    run_pass(0, 0, 0);
    random_coords(150, 110);
    run_pass(0, 0, 0);
    check("t4_len", last_len, 502);
    check("t4_black", last_black, 250);
    check("t4_white", last_white, 100);

    random_coords(170, 125);
    in_vis = N'($urandom);
    run_pass(40, 0, 1);
    random_coords(170, 125);
    in_vis = N'($urandom);
    run_pass(-1, 0, 0);

    for (int r = 0; r < 6; r++) begin
      random_coords(170, 125);
      in_vis = N'($urandom);
      run_pass((r % 2 == 0) ? $urandom_range(1, 30) : 0, 0, 1);
    end

    random_coords(150, 110);
    in_vis = '1;
    run_pass(0, 0, 0);
    random_coords(150, 110);
    in_vis = N'($urandom) | N'(1);
    run_pass(0, 5, 0);
    random_coords(150, 110);
    in_vis = N'($urandom) | N'(1);
    run_pass(0, 0, 0);
    check("t6_no_erase", last_black, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
